// File: rtl/nibble_serial_adder_seq.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_seq
//
// Performs a W-bit addition (W = 4*NIBBLES) by driving an external 4-bit
// combinational adder one nibble per cycle, least-significant nibble first,
// and chaining each nibble's carry-out into the next nibble's carry-in.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid / in_ready   operand handshake (op_a, op_b, op_cin)
//   op_a, op_b [W]        operands, sampled only on the accepting edge
//   op_cin                carry into nibble 0
//   add_a, add_b, add_cin nibble and carry driven to the external adder
//   add_s, add_cout       sum and carry from the external adder (same cycle)
//   out_valid / out_ready result handshake (sum, cout)
//   sum [W], cout         result; {cout,sum} = op_a + op_b + op_cin
//   ovf                   signed overflow flag, present only when the macro
//                         NIBBLE_SERIAL_OVF_FLAG_EN is defined
//
// Parameter NIBBLES: number of 4-bit slices, legal range 1..16.
// Latency: out_valid rises NIBBLES cycles after the accepting edge.
// -----------------------------------------------------------------------------
module nibble_serial_adder_seq #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_cin,
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_cin,
    input  logic [3:0]   add_s,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
    output logic         ovf,
`endif
    output logic [W-1:0] sum,
    output logic         cout
);

    // idx needs at least one bit even when there is a single nibble.
    localparam int            IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_run  = 2'd1,
        st_done = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_reg, b_reg, sum_reg;
    logic          cout_reg;
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
    logic          ovf_reg;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= st_idle;
        else        state <= state_next;
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case leaves a signal unassigned (which would infer a latch).
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = 4'h0;
        add_b      = 4'h0;
        add_cin    = 1'b0;

        unique case (state)
            st_idle: begin
                in_ready = 1'b1;
                if (in_valid) state_next = st_run;
            end
            st_run: begin
                add_a   = a_reg[4*int'(idx) +: 4];
                add_b   = b_reg[4*int'(idx) +: 4];
                add_cin = carry;
                if (idx == LAST) state_next = st_done;
            end
            st_done: begin
                out_valid = 1'b1;
                if (out_ready) state_next = st_idle;
            end
            default: state_next = st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, nibble-by-nibble sum accumulation
    // ------------------------------------------------------------------
    // NOTE: every datapath register is reset so an aborted operation can
    // never leave stale or partial results on sum/cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
            ovf_reg  <= 1'b0;
`endif
        end else begin
            unique case (state)
                st_idle: begin
                    if (in_valid) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        carry <= op_cin;
                        idx   <= '0;
                    end
                end
                st_run: begin
                    sum_reg[4*int'(idx) +: 4] <= add_s;
                    carry                     <= add_cout;
                    if (idx == LAST) begin
                        // Top nibble: its carry-out is the final carry, and
                        // its sum MSB is the result sign bit.
                        idx      <= '0;
                        cout_reg <= add_cout;
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
                        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) &&
                                    (add_s[3] != a_reg[W-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;  // st_done holds the result until out_ready
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder_seq
//
// Bench for nibble_serial_adder_seq with NIBBLES=4 and a behavioural 4-bit
// adder closing the loop. Expected results are pushed into a queue when an
// operand pair is accepted; an independent monitor pops and compares whenever
// the DUT completes a result handshake.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a, op_b;
    logic         op_cin;
    logic [3:0]   add_a, add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
    logic         ovf;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    logic [3:0] seen_a   [NIB];
    logic       seen_cin [NIB];

    always #5 clk = ~clk;

    // External 4-bit adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    nibble_serial_adder_seq #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_cin   (op_cin),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
        .ovf      (ovf),
`endif
        .sum      (sum),
        .cout     (cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every completed result handshake against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum=0x%0h cout=%0b with empty queue", sum, cout);
                end else begin
                    e = sb.pop_front();
                    popped++;
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
`ifdef NIBBLE_SERIAL_OVF_FLAG_EN
                    check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    // Present an operand pair for one edge; afterwards scramble the inputs
    // so any late sampling of op_a/op_b/op_cin would corrupt the result.
    task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_cin   = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        op_cin   = ~c;
    endtask

    // Issue one operation, queue its hand-computed result, record the adder
    // drive per RUN cycle and check the accept-to-out_valid latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int cnt;
        accept_op(a, b, c);
        sb.push_back('{sum: es, cout: ec, ovf: eo});
        pushed++;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            if (cnt < NIB) begin
                seen_a[cnt]   = add_a;
                seen_cin[cnt] = add_cin;
            end
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", 32'(cnt), 32'(NIB));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        out_ready = 1'b1;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_add_a",     32'(add_a),     32'd0);
        check("rst_add_b",     32'(add_b),     32'd0);
        check("rst_add_cin",   32'(add_cin),   32'd0);

        // Simple case
        run_op(16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Full ripple: carry into nibbles 1..3
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("ripple_cin0", 32'(seen_cin[0]), 32'd0);
        check("ripple_cin1", 32'(seen_cin[1]), 32'd1);
        check("ripple_cin2", 32'(seen_cin[2]), 32'd1);
        check("ripple_cin3", 32'(seen_cin[3]), 32'd1);
        @(posedge clk); #1;

        // Nibble ordering and carry-in
        run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        check("seq_a0",   32'(seen_a[0]),   32'h4);
        check("seq_a1",   32'(seen_a[1]),   32'h3);
        check("seq_a2",   32'(seen_a[2]),   32'h2);
        check("seq_a3",   32'(seen_a[3]),   32'h1);
        check("seq_cin0", 32'(seen_cin[0]), 32'd1);
        @(posedge clk); #1;

        // Maximum operands with carry-in
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Signed overflow case
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        @(posedge clk); #1;

        // Backpressure: result must hold; in_valid during the wait is ignored
        out_ready = 1'b0;
        run_op(16'hAAAA, 16'h7777, 1'b0, 16'h2221, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum",       32'(sum),       32'h2221);
            check("bp_cout",      32'(cout),      32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            if (i == 2) begin
                in_valid = 1'b1;
                op_a     = 16'h1111;
                op_b     = 16'h1111;
                op_cin   = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released_valid", 32'(out_valid), 32'd0);
        check("bp_released_ready", 32'(in_ready),  32'd1);

        // Reset after two RUN cycles: discarded, IDLE immediately
        accept_op(16'h1234, 16'h1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",       32'(sum),       32'd0);
        check("mid_rst_cout",      32'(cout),      32'd0);
        check("mid_rst_add_a",     32'(add_a),     32'd0);
        check("mid_rst_add_cin",   32'(add_cin),   32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty",   32'(sb.size()), 32'd0);
        check("results_count", 32'(popped),    32'(pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
